// File: rtl/joybus_rx.sv
`default_nettype none
// ============================================================================
//  Module   : joybus_rx
//  Purpose  : Joybus line receiver. Measures each bit from its falling edge,
//             samples the line SAMPLE_DLY clocks later, assembles MSB-first
//             bytes and detects end of frame on a long high (idle) or a long
//             low (abort) line.
//  Revision : 1.0  initial release
// ============================================================================
module joybus_rx #(
    parameter int SAMPLE_DLY   = 100,
    parameter int IDLE_TIMEOUT = 250,
    parameter int LOW_TIMEOUT  = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       JB_RX,
    input  logic       rx_en,
    output logic [7:0] rx_data,
    output logic       rx_byte_vld,
    output logic       frame_done,
    output logic       frame_err,
    output logic [5:0] byte_cnt
);

    // One counter serves all three timeouts, so it is sized for the largest.
    localparam int c_MAX_AB  = (SAMPLE_DLY > IDLE_TIMEOUT) ? SAMPLE_DLY : IDLE_TIMEOUT;
    localparam int c_MAX_DLY = (c_MAX_AB > LOW_TIMEOUT) ? c_MAX_AB : LOW_TIMEOUT;
    localparam int c_CNT_W   = $clog2(c_MAX_DLY) + 1;

    localparam logic [c_CNT_W-1:0] c_SAMPLE_LAST = c_CNT_W'(SAMPLE_DLY - 1);
    localparam logic [c_CNT_W-1:0] c_IDLE_LAST   = c_CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_LOW_LAST    = c_CNT_W'(LOW_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_WAIT_SAMPLE = 2'd1,
        S_WAIT_HIGH   = 2'd2,
        S_WAIT_FALL   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_hist;
    logic                 w_fall;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2:0]           r_bit_cnt;
    logic [6:0]           r_shift;
    logic                 w_start;
    logic                 w_sample;
    logic                 w_end;
    logic                 w_end_err;

    assign w_fall = r_hist & ~r_sync2;

    // Two-flop synchronizer plus history flop; idle-high so they reset to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= 1'b1;
        end else begin
            r_sync1 <= JB_RX;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    // State register and shared cycle counter (cleared on every state change).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_state != S_IDLE) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    // Next-state decode and datapath control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_sample    = 1'b0;
        w_end       = 1'b0;
        w_end_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall && rx_en) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_WAIT_SAMPLE;
                end
            end
            S_WAIT_SAMPLE: begin
                // Falling edges here are glitches inside the bit cell: ignored.
                if (r_cnt == c_SAMPLE_LAST) begin
                    w_sample    = 1'b1;
                    w_state_nxt = r_sync2 ? S_WAIT_FALL : S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (r_sync2) begin
                    w_state_nxt = S_WAIT_FALL;
                end else if (r_cnt == c_LOW_LAST) begin
                    w_end       = 1'b1;
                    w_end_err   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_FALL: begin
                if (w_fall) begin
                    w_state_nxt = S_WAIT_SAMPLE;
                end else if (r_cnt == c_IDLE_LAST) begin
                    // A clean frame ends with exactly one stop bit after whole bytes.
                    w_end       = 1'b1;
                    w_end_err   = (r_bit_cnt != 3'd1) || (byte_cnt == 6'd0);
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Transmitter owns the line: drop the frame silently.
        if (!rx_en && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_start     = 1'b0;
            w_sample    = 1'b0;
            w_end       = 1'b0;
            w_end_err   = 1'b0;
        end
    end

    // Bit/byte assembly, byte and frame counters, output strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt   <= 3'd0;
            r_shift     <= 7'd0;
            rx_data     <= 8'h00;
            byte_cnt    <= 6'd0;
            rx_byte_vld <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_byte_vld <= 1'b0;
            frame_done  <= 1'b0;
            if (w_start) begin
                r_bit_cnt <= 3'd0;
                byte_cnt  <= 6'd0;
            end
            if (w_sample) begin
                r_shift <= {r_shift[5:0], r_sync2};
                if (r_bit_cnt == 3'd7) begin
                    r_bit_cnt   <= 3'd0;
                    rx_data     <= {r_shift, r_sync2};
                    rx_byte_vld <= 1'b1;
                    if (byte_cnt != 6'd63) begin
                        byte_cnt <= byte_cnt + 6'd1;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
            end
            if (w_end) begin
                frame_done <= 1'b1;
                frame_err  <= w_end_err;
            end
        end
    end

endmodule
`default_nettype wire
